// File: rtl/multicycle_sequencer_if.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer_if
// Bundles the signals between the multicycle phase sequencer and the
// surrounding datapath / decoder.
//
//   Datapath -> sequencer:
//     opcode[5:0]       IR[31:26], valid from the cycle after IRWrite
//     funct[5:0]        IR[5:0]
//     overflowflag      ALU overflow (combinational)
//     divby0flag        divider divide-by-zero indication
//     md_done           mult/div unit finished (single-cycle pulse)
//   Sequencer -> datapath:
//     IorD              0 = PC addresses memory, 1 = ALU/exception address
//     IRWrite           load IR
//     pc_inc            PC <= PC + 4
//     exec_en           enables decoder outputs
//     step[2:0]         execute step index, 0-based
//     md_start          one-cycle start pulse to mult/div unit
//     EPCWrite          EPC <= PC - 4
//     ExceptionAdress   select exception vector address on memory bus
//     pc_exc_load       PC <= zero-extended vector byte
//     exc_cause[1:0]    0 invalid opcode, 1 overflow, 2 divide by zero
//     state_dbg[2:0]    current state encoding
//
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface multicycle_sequencer_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       overflowflag;
   logic       divby0flag;
   logic       md_done;

   logic       IorD;
   logic       IRWrite;
   logic       pc_inc;
   logic       exec_en;
   logic [2:0] step;
   logic       md_start;
   logic       EPCWrite;
   logic       ExceptionAdress;
   logic       pc_exc_load;
   logic [1:0] exc_cause;
   logic [2:0] state_dbg;

   modport master (
      input  opcode, funct, overflowflag, divby0flag, md_done,
      output IorD, IRWrite, pc_inc, exec_en, step, md_start,
             EPCWrite, ExceptionAdress, pc_exc_load, exc_cause, state_dbg
   );

   modport slave (
      output opcode, funct, overflowflag, divby0flag, md_done,
      input  IorD, IRWrite, pc_inc, exec_en, step, md_start,
             EPCWrite, ExceptionAdress, pc_exc_load, exc_cause, state_dbg
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Phase controller for a multicycle CPU: fetch wait, IR latch, decode,
// execute steps, mult/div wait and exception entry. Sits upstream of the
// combinational opcode decoder, which only drives datapath controls while
// exec_en is high.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    multicycle_sequencer_if.master (instruction fields, ALU/MD
//          status in; phase controls, exception controls, debug state out)
//
// All outputs are registered and derived from the next-state values, so
// they change together with state_dbg and never depend combinationally on
// the inputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module multicycle_sequencer #(
   parameter int MEM_WAIT   = 2,   // memory read latency, 1..7
   parameter int MD_TIMEOUT = 63   // max MD_WAIT cycles, 1..255
) (
   input  logic                          clk,
   input  logic                          reset,
   multicycle_sequencer_if.master        bus
);

   typedef enum logic [2:0] {
      FETCH_WAIT  = 3'd0,
      FETCH_LATCH = 3'd1,
      DECODE      = 3'd2,
      EXEC        = 3'd3,
      MD_WAIT     = 3'd4,
      EXC_SAVE    = 3'd5,
      EXC_WAIT    = 3'd6,
      EXC_LOAD    = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_INV, C_ALU, C_JUMP, C_BRANCH, C_MEM, C_MD
   } cls_t;

   localparam logic [7:0] MEM_LAST  = 8'(MEM_WAIT - 1);
   localparam logic [7:0] MD_LAST   = 8'(MD_TIMEOUT - 1);
   // Step counter is 4 bits wide so MEM_WAIT+2 steps fit for every legal
   // MEM_WAIT; only the low 3 bits leave the block.
   localparam logic [3:0] MEM_STEPS = 4'(MEM_WAIT + 2);

   state_t     state_reg,  state_next;
   logic [7:0] cnt_reg,    cnt_next;
   logic [3:0] step_reg,   step_next;
   logic [3:0] nsteps_reg, nsteps_next;
   logic       md_reg,     md_next;     // instruction uses the mult/div unit
   logic       ovf_reg,    ovf_next;    // overflow-checked ALU op
   logic       div_reg,    div_next;    // divide op, divby0flag honoured
   logic [1:0] cause_reg,  cause_next;

   cls_t cls;
   logic rtype;
   logic ovf_op;
   logic div_op;

   // ---------------------------------------------------------------------
   // Instruction classification (only consumed in DECODE)
   // ---------------------------------------------------------------------
   always_comb begin
      rtype  = (bus.opcode == 6'h00);
      ovf_op = (rtype && (bus.funct == 6'h20 || bus.funct == 6'h22)) ||
               (bus.opcode == 6'h08);
      div_op = (rtype && bus.funct == 6'h1a) || (bus.opcode == 6'h01);
      cls    = C_INV;
      if (rtype) begin
         case (bus.funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00,
            6'h02, 6'h03, 6'h04, 6'h07, 6'h10, 6'h12: cls = C_ALU;
            6'h08, 6'h13, 6'h0d:                      cls = C_JUMP;
            6'h18, 6'h1a:                             cls = C_MD;
            default:                                  cls = C_INV;
         endcase
      end else begin
         case (bus.opcode)
            6'h08, 6'h09, 6'h0a, 6'h0f:               cls = C_ALU;
            6'h02, 6'h03:                             cls = C_JUMP;
            6'h04, 6'h05, 6'h06, 6'h07:               cls = C_BRANCH;
            6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2b: cls = C_MEM;
            6'h01:                                    cls = C_MD;
            default:                                  cls = C_INV;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic. The wait counter and step index fall back to zero in
   // every state that does not own them, so each counting state starts at 0.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      cnt_next    = 8'd0;
      step_next   = 4'd0;
      nsteps_next = nsteps_reg;
      md_next     = md_reg;
      ovf_next    = ovf_reg;
      div_next    = div_reg;
      cause_next  = cause_reg;

      case (state_reg)
         FETCH_WAIT: begin
            if (cnt_reg == MEM_LAST) state_next = FETCH_LATCH;
            else                     cnt_next   = cnt_reg + 8'd1;
         end
         FETCH_LATCH: state_next = DECODE;
         DECODE: begin
            md_next  = (cls == C_MD);
            ovf_next = ovf_op;
            div_next = div_op;
            case (cls)
               C_ALU, C_MD:      nsteps_next = 4'd2;
               C_MEM:            nsteps_next = MEM_STEPS;
               default:          nsteps_next = 4'd1;
            endcase
            if (cls == C_INV) begin
               cause_next = 2'd0;
               state_next = EXC_SAVE;
            end else begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            if (md_reg) begin
               // Step 0 launches the unit; step 1 is the HI/LO writeback.
               state_next = (step_reg == 4'd0) ? MD_WAIT : FETCH_WAIT;
            end else if (ovf_reg && step_reg == 4'd0 && bus.overflowflag) begin
               // Abort before the writeback step.
               cause_next = 2'd1;
               state_next = EXC_SAVE;
            end else if (step_reg == nsteps_reg - 4'd1) begin
               state_next = FETCH_WAIT;
            end else begin
               step_next  = step_reg + 4'd1;
            end
         end
         MD_WAIT: begin
            if (bus.md_done) begin
               if (div_reg && bus.divby0flag) begin
                  cause_next = 2'd2;
                  state_next = EXC_SAVE;
               end else begin
                  step_next  = 4'd1;
                  state_next = EXEC;
               end
            end else if (cnt_reg == MD_LAST) begin
               state_next = FETCH_WAIT;   // silent abort, no exception
            end else begin
               cnt_next   = cnt_reg + 8'd1;
            end
         end
         EXC_SAVE: state_next = EXC_WAIT;
         EXC_WAIT: begin
            if (cnt_reg == MEM_LAST) state_next = EXC_LOAD;
            else                     cnt_next   = cnt_reg + 8'd1;
         end
         EXC_LOAD: state_next = FETCH_WAIT;
      endcase
   end

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   logic exc_path_next;
   assign exc_path_next = (state_next == EXC_SAVE) || (state_next == EXC_WAIT) ||
                          (state_next == EXC_LOAD);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg           <= FETCH_WAIT;
         cnt_reg             <= 8'd0;
         step_reg            <= 4'd0;
         nsteps_reg          <= 4'd0;
         md_reg              <= 1'b0;
         ovf_reg             <= 1'b0;
         div_reg             <= 1'b0;
         cause_reg           <= 2'd0;
         bus.IorD            <= 1'b0;
         bus.IRWrite         <= 1'b0;
         bus.pc_inc          <= 1'b0;
         bus.exec_en         <= 1'b0;
         bus.step            <= 3'd0;
         bus.md_start        <= 1'b0;
         bus.EPCWrite        <= 1'b0;
         bus.ExceptionAdress <= 1'b0;
         bus.pc_exc_load     <= 1'b0;
         bus.exc_cause       <= 2'd0;
         bus.state_dbg       <= 3'd0;
      end else begin
         state_reg           <= state_next;
         cnt_reg             <= cnt_next;
         step_reg            <= step_next;
         nsteps_reg          <= nsteps_next;
         md_reg              <= md_next;
         ovf_reg             <= ovf_next;
         div_reg             <= div_next;
         cause_reg           <= cause_next;
         bus.IorD            <= exc_path_next;
         bus.IRWrite         <= (state_next == FETCH_LATCH);
         bus.pc_inc          <= (state_next == FETCH_LATCH);
         bus.exec_en         <= (state_next == EXEC);
         bus.step            <= (state_next == EXEC) ? step_next[2:0] : 3'd0;
         bus.md_start        <= (state_next == EXEC) && md_next && (step_next == 4'd0);
         bus.EPCWrite        <= (state_next == EXC_SAVE);
         bus.ExceptionAdress <= exc_path_next;
         bus.pc_exc_load     <= (state_next == EXC_LOAD);
         bus.exc_cause       <= cause_next;
         bus.state_dbg       <= state_next;
      end
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench for multicycle_sequencer (MEM_WAIT=2, MD_TIMEOUT=63).
// The stimulus process drives the instruction inputs cycle by cycle and
// pushes the hand-derived output vector expected in that cycle into a
// queue; a separate monitor pops one entry per cycle on the falling edge
// and compares it with every DUT output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_sequencer;

   localparam logic [2:0] S_FW = 3'd0, S_FL = 3'd1, S_DE = 3'd2, S_EX = 3'd3,
                          S_MD = 3'd4, S_ES = 3'd5, S_EW = 3'd6, S_EL = 3'd7;

   typedef struct {
      logic [15:0] v;
      string       tag;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset;
   exp_t   q[$];
   string  tag;
   logic [1:0] ec;          // exception cause expected to be held
   int     n_vec = 0;
   int     n_err = 0;

   multicycle_sequencer_if bus ();

   multicycle_sequencer #(.MEM_WAIT(2), .MD_TIMEOUT(63)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Push the expected outputs of the current cycle, then move to the next.
   task automatic c(input logic [2:0] st, input logic [2:0] stp = 3'd0,
                    input logic mds = 1'b0);
      exp_t e;
      logic exc;
      exc   = (st == S_ES) || (st == S_EW) || (st == S_EL);
      e.v   = {exc, st == S_FL, st == S_FL, st == S_EX, stp, mds,
               st == S_ES, exc, st == S_EL, ec, st};
      e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic start(input string name);
      tag = name;
      $display("test %s", name);
   endtask

   // Two fetch-wait cycles, IR latch, decode.
   task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
      bus.opcode       = op;
      bus.funct        = fn;
      bus.overflowflag = 1'b0;
      bus.divby0flag   = 1'b0;
      bus.md_done      = 1'b0;
      c(S_FW); c(S_FW); c(S_FL); c(S_DE);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t        e;
         logic [15:0] got;
         e   = q.pop_front();
         got = {bus.IorD, bus.IRWrite, bus.pc_inc, bus.exec_en, bus.step,
                bus.md_start, bus.EPCWrite, bus.ExceptionAdress,
                bus.pc_exc_load, bus.exc_cause, bus.state_dbg};
         n_vec++;
         if (got !== e.v) begin
            n_err++;
            $display("FAIL %s: outputs got %h required %h (state got %0d required %0d)",
                     e.tag, got, e.v, got[2:0], e.v[2:0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b0;
      ec               = 2'd0;
      bus.opcode       = 6'h00;
      bus.funct        = 6'h00;
      bus.overflowflag = 1'b0;
      bus.divby0flag   = 1'b0;
      bus.md_done      = 1'b0;

      // Reset held for three edges; outputs all zero throughout.
      start("reset");
      @(posedge clk); #1;
      c(S_FW); c(S_FW);
      reset = 1'b1;

      start("alu_add");          // 6 cycles
      fetch(6'h00, 6'h20); c(S_EX, 3'd0); c(S_EX, 3'd1);

      start("and_ovf_unchecked"); // overflow ignored on non-checked op
      fetch(6'h00, 6'h24);
      bus.overflowflag = 1'b1; c(S_EX, 3'd0);
      bus.overflowflag = 1'b0; c(S_EX, 3'd1);

      start("sub_ovf_step1");    // overflow only matters in step 0
      fetch(6'h00, 6'h22); c(S_EX, 3'd0);
      bus.overflowflag = 1'b1; c(S_EX, 3'd1);
      bus.overflowflag = 1'b0;

      start("jump");             // 5 cycles
      fetch(6'h02, 6'h00); c(S_EX, 3'd0);

      start("jr");
      fetch(6'h00, 6'h08); c(S_EX, 3'd0);

      start("branch");
      fetch(6'h07, 6'h3f); c(S_EX, 3'd0);

      start("mem_lw");           // 8 cycles
      fetch(6'h23, 6'h00);
      c(S_EX, 3'd0); c(S_EX, 3'd1); c(S_EX, 3'd2); c(S_EX, 3'd3);

      start("addi_ovf");
      fetch(6'h08, 6'h00);
      bus.overflowflag = 1'b1; c(S_EX, 3'd0);
      bus.overflowflag = 1'b0; ec = 2'd1;
      c(S_ES); c(S_EW); c(S_EW); c(S_EL);

      start("div_by0");
      fetch(6'h00, 6'h1a); c(S_EX, 3'd0, 1'b1);
      repeat (9) c(S_MD);
      bus.md_done = 1'b1; bus.divby0flag = 1'b1; c(S_MD);
      bus.md_done = 1'b0; bus.divby0flag = 1'b0; ec = 2'd2;
      c(S_ES); c(S_EW); c(S_EW); c(S_EL);

      start("invalid_op3f");
      fetch(6'h3f, 6'h00); ec = 2'd0;
      c(S_ES); c(S_EW); c(S_EW); c(S_EL);

      start("op01_by0_first_cycle");
      fetch(6'h01, 6'h00); c(S_EX, 3'd0, 1'b1);
      bus.md_done = 1'b1; bus.divby0flag = 1'b1; c(S_MD);
      bus.md_done = 1'b0; bus.divby0flag = 1'b0; ec = 2'd2;
      c(S_ES); c(S_EW); c(S_EW); c(S_EL);

      start("invalid_funct21");
      fetch(6'h00, 6'h21); ec = 2'd0;
      c(S_ES); c(S_EW); c(S_EW); c(S_EL);

      start("div_ok_early_done"); // md_done in EXEC step 0 is ignored
      fetch(6'h00, 6'h1a);
      bus.md_done = 1'b1; c(S_EX, 3'd0, 1'b1);
      bus.md_done = 1'b0;
      repeat (9) c(S_MD);
      bus.md_done = 1'b1; c(S_MD);
      bus.md_done = 1'b0; c(S_EX, 3'd1);

      start("mult_by0_ignored");
      fetch(6'h00, 6'h18); c(S_EX, 3'd0, 1'b1);
      c(S_MD); c(S_MD);
      bus.md_done = 1'b1; bus.divby0flag = 1'b1; c(S_MD);
      bus.md_done = 1'b0; bus.divby0flag = 1'b0; c(S_EX, 3'd1);

      start("mult_timeout");     // exactly 63 MD_WAIT cycles, then fetch
      fetch(6'h00, 6'h18); c(S_EX, 3'd0, 1'b1);
      repeat (63) c(S_MD);

      start("reset_in_md_wait");
      fetch(6'h00, 6'h18); c(S_EX, 3'd0, 1'b1);
      c(S_MD); c(S_MD);
      reset = 1'b0; c(S_MD);
      reset = 1'b1;
      bus.opcode = 6'h00; bus.funct = 6'h20;
      bus.md_done = 1'b1; c(S_FW);     // late md_done must be ignored
      bus.md_done = 1'b0; c(S_FW); c(S_FL); c(S_DE);
      c(S_EX, 3'd0); c(S_EX, 3'd1);

      start("reset_in_exc_wait");
      fetch(6'h08, 6'h00);
      bus.overflowflag = 1'b1; c(S_EX, 3'd0);
      bus.overflowflag = 1'b0; ec = 2'd1;
      c(S_ES);
      reset = 1'b0; c(S_EW);
      reset = 1'b1; ec = 2'd0;          // cause cleared by reset

      start("jump_after_reset");
      fetch(6'h03, 6'h00); c(S_EX, 3'd0);

      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard: %0d expected vectors never compared", q.size());
      end
      if (n_vec < 150) begin
         n_err++;
         $display("FAIL scoreboard: only %0d vectors compared", n_vec);
      end
      if (n_err == 0) $display("PASS");
      else            $display("FAIL %0d errors", n_err);
      $finish;
   end

endmodule
